// File: rtl/section_mean_estimator.sv
// section_mean_estimator
// Accumulates 2^LOG2_N samples for each of the four ADC sections, then
// publishes all four means together (FRAC_W fractional bits, ufix32).
// Published means stay frozen while the next block is being accumulated.
module section_mean_estimator #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              sample_valid,
    input  logic [1:0]        adc_section,
    input  logic [DATA_W-1:0] adc_sample,
    output logic [31:0]       mean_1_o,
    output logic [31:0]       mean_2_o,
    output logic [31:0]       mean_3_o,
    output logic [31:0]       mean_4_o,
    output logic              means_valid,
    output logic              update_pulse,
    output logic              busy
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int SHIFT = LOG2_N - FRAC_W;
    localparam logic [CNT_W-1:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q  [4];
    logic [ACC_W-1:0]  acc_d  [4];
    logic [CNT_W-1:0]  cnt_q  [4];
    logic [CNT_W-1:0]  cnt_d  [4];
    logic [31:0]       mean_q [4];
    logic [31:0]       mean_d [4];
    logic              means_valid_q, means_valid_d;
    logic              update_pulse_q, update_pulse_d;

    // Per-section datapath: acceptance decision, incremented values and
    // the shifted mean candidate computed from the current accumulator.
    logic [3:0]        take;
    logic [3:0]        full_next;
    logic [ACC_W-1:0]  acc_inc  [4];
    logic [CNT_W-1:0]  cnt_inc  [4];
    logic [31:0]       mean_calc[4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_section
            // A sample is taken only while accumulating and only until the
            // section has its N samples; extra samples are silently dropped.
            assign take[gi]      = (state_q == ACCUM) && sample_valid &&
                                   (adc_section == 2'(gi)) && (cnt_q[gi] != N_CNT);
            assign acc_inc[gi]   = acc_q[gi] + ACC_W'(adc_sample);
            assign cnt_inc[gi]   = cnt_q[gi] + CNT_W'(take[gi]);
            // Completion is judged on the post-edge counts so the accepting
            // edge itself moves the FSM into UPDATE.
            assign full_next[gi] = (cnt_inc[gi] == N_CNT);
            assign mean_calc[gi] = 32'(acc_q[gi] >> SHIFT);
        end
    endgenerate

    // Next-state and next-datapath computation for the estimation FSM.
    always_comb begin
        state_d        = state_q;
        means_valid_d  = means_valid_q;
        update_pulse_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            acc_d[k]  = acc_q[k];
            cnt_d[k]  = cnt_q[k];
            mean_d[k] = mean_q[k];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < 4; k++) begin
                        acc_d[k] = '0;
                        cnt_d[k] = '0;
                    end
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                for (int k = 0; k < 4; k++) begin
                    if (take[k]) begin
                        acc_d[k] = acc_inc[k];
                        cnt_d[k] = cnt_inc[k];
                    end
                end
                if (&full_next) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // All four means are loaded on the same edge so the consumer
                // never observes a mixed set.
                for (int k = 0; k < 4; k++) begin
                    mean_d[k] = mean_calc[k];
                end
                update_pulse_d = 1'b1;
                means_valid_d  = 1'b1;
                if (continuous) begin
                    for (int k = 0; k < 4; k++) begin
                        acc_d[k] = '0;
                        cnt_d[k] = '0;
                    end
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulators, counters and published outputs; reset clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            means_valid_q  <= 1'b0;
            update_pulse_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k]  <= '0;
                cnt_q[k]  <= '0;
                mean_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            means_valid_q  <= means_valid_d;
            update_pulse_q <= update_pulse_d;
            for (int k = 0; k < 4; k++) begin
                acc_q[k]  <= acc_d[k];
                cnt_q[k]  <= cnt_d[k];
                mean_q[k] <= mean_d[k];
            end
        end
    end

    assign mean_1_o     = mean_q[0];
    assign mean_2_o     = mean_q[1];
    assign mean_3_o     = mean_q[2];
    assign mean_4_o     = mean_q[3];
    assign means_valid  = means_valid_q;
    assign update_pulse = update_pulse_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_section_mean_estimator.sv
// Testbench for section_mean_estimator: two instances (small N=4 and default
// N=1024) driven from shared sample inputs with separate start lines, checked
// every cycle against a transaction-level reference model.
module tb_section_mean_estimator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_s, start_b;
    logic        continuous;
    logic        sample_valid;
    logic [1:0]  adc_section;
    logic [15:0] adc_sample;

    logic [31:0] mean_s [4];
    logic [31:0] mean_b [4];
    logic        valid_s, pulse_s, busy_s;
    logic        valid_b, pulse_b, busy_b;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    section_mean_estimator #(.DATA_W(16), .LOG2_N(2), .FRAC_W(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .continuous(continuous),
        .sample_valid(sample_valid), .adc_section(adc_section), .adc_sample(adc_sample),
        .mean_1_o(mean_s[0]), .mean_2_o(mean_s[1]), .mean_3_o(mean_s[2]), .mean_4_o(mean_s[3]),
        .means_valid(valid_s), .update_pulse(pulse_s), .busy(busy_s)
    );

    section_mean_estimator dut_b (
        .clk(clk), .rst(rst), .start(start_b), .continuous(continuous),
        .sample_valid(sample_valid), .adc_section(adc_section), .adc_sample(adc_sample),
        .mean_1_o(mean_b[0]), .mean_2_o(mean_b[1]), .mean_3_o(mean_b[2]), .mean_4_o(mean_b[3]),
        .means_valid(valid_b), .update_pulse(pulse_b), .busy(busy_b)
    );

    // Reference model: index 0 = small instance, 1 = default instance.
    longint m_sum  [2][4];
    int     m_cnt  [2][4];
    longint m_mean [2][4];
    bit     m_run  [2];
    bit     m_upd  [2];
    bit     m_valid[2];
    bit     m_pulse[2];

    task automatic check_val(input string tag, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_upd[d] = 0; m_valid[d] = 0; m_pulse[d] = 0;
            for (int k = 0; k < 4; k++) begin
                m_sum[d][k] = 0; m_cnt[d][k] = 0; m_mean[d][k] = 0;
            end
        end
    endtask

    // One clock edge of behaviour, from the current inputs.
    task automatic model_step(input int d);
        int  lg;
        int  fr;
        int  n;
        bit  st;
        bit  all_full;
        lg = (d == 0) ? 2 : 10;
        fr = (d == 0) ? 1 : 4;
        n  = 1 << lg;
        st = (d == 0) ? start_s : start_b;
        m_pulse[d] = 0;
        if (m_upd[d]) begin
            for (int k = 0; k < 4; k++) m_mean[d][k] = (m_sum[d][k] << fr) >> lg;
            m_pulse[d] = 1;
            m_valid[d] = 1;
            m_upd[d]   = 0;
            if (continuous) begin
                for (int k = 0; k < 4; k++) begin m_sum[d][k] = 0; m_cnt[d][k] = 0; end
            end else begin
                m_run[d] = 0;
            end
        end else if (m_run[d]) begin
            if (sample_valid && m_cnt[d][adc_section] < n) begin
                m_sum[d][adc_section] += longint'(adc_sample);
                m_cnt[d][adc_section] += 1;
            end
            all_full = 1;
            for (int k = 0; k < 4; k++) if (m_cnt[d][k] != n) all_full = 0;
            if (all_full) m_upd[d] = 1;
        end else if (st) begin
            for (int k = 0; k < 4; k++) begin m_sum[d][k] = 0; m_cnt[d][k] = 0; end
            m_run[d] = 1;
        end
    endtask

    task automatic check_dut(input int d);
        for (int k = 0; k < 4; k++)
            check_val($sformatf("d%0d_mean%0d", d, k + 1),
                      (d == 0) ? mean_s[k] : mean_b[k], m_mean[d][k]);
        check_val($sformatf("d%0d_pulse", d), (d == 0) ? pulse_s : pulse_b, m_pulse[d]);
        check_val($sformatf("d%0d_valid", d), (d == 0) ? valid_s : valid_b, m_valid[d]);
        check_val($sformatf("d%0d_busy", d),  (d == 0) ? busy_s  : busy_b,
                  (m_run[d] || m_upd[d]) ? 1 : 0);
        if (m_pulse[d])
            $display("update dut%0d cycle %0d: means %0d %0d %0d %0d", d, cyc,
                     m_mean[d][0], m_mean[d][1], m_mean[d][2], m_mean[d][3]);
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic feed(input int sec, input int val);
        sample_valid = 1'b1;
        adc_section  = sec[1:0];
        adc_sample   = val[15:0];
        cycle();
        sample_valid = 1'b0;
        adc_section  = 2'($urandom);
        adc_sample   = 16'($urandom);
    endtask

    task automatic start_small();
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
    endtask

    task automatic fill_small(input int val);
        for (int i = 0; i < 16; i++) feed(i % 4, val);
    endtask

    int accept_edge;
    int lat;
    int bound;

    initial begin
        rst = 1'b1; start_s = 0; start_b = 0; continuous = 0;
        sample_valid = 0; adc_section = 0; adc_sample = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        rst = 1'b0;
        cycle();

        // 1: basic run with mixed values
        start_small();
        for (int i = 0; i < 4; i++) feed(0, 10 + i);
        for (int i = 0; i < 4; i++) feed(1, 100);
        for (int i = 0; i < 4; i++) feed(2, 0);
        for (int i = 0; i < 4; i++) feed(3, 65535);
        cycle();
        check_val("t1_mean1", mean_s[0], 23);
        check_val("t1_mean2", mean_s[1], 200);
        check_val("t1_mean3", mean_s[2], 0);
        check_val("t1_mean4", mean_s[3], 131070);
        check_val("t1_pulse", pulse_s, 1);
        cycle();
        check_val("t1_busy_after", busy_s, 0);

        // 2: surplus samples for section 0, sample during UPDATE
        start_small();
        for (int i = 0; i < 6; i++) feed(0, 10 + i);
        for (int i = 0; i < 4; i++) feed(1, 100);
        for (int i = 0; i < 4; i++) feed(2, 0);
        for (int i = 0; i < 4; i++) feed(3, 65535);
        feed(1, 999);
        check_val("t2_mean1", mean_s[0], 23);
        check_val("t2_mean2", mean_s[1], 200);
        cycle();

        // 3: default config, round robin with random gaps
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            while ($urandom_range(0, 3) == 0) cycle();
            feed(i % 4, 1000);
        end
        accept_edge = cyc;
        lat = -1;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            cycle();
            if (pulse_b) lat = cyc - accept_edge;
        end
        check_val("t3_latency", lat, 1);
        for (int k = 0; k < 4; k++) check_val("t3_mean", mean_b[k], 16000);

        // 4: continuous mode, outputs hold during second accumulation
        continuous = 1'b1;
        start_small();
        fill_small(8);
        cycle();
        check_val("t4_first_mean", mean_s[0], 16);
        check_val("t4_busy_cont", busy_s, 1);
        for (int i = 0; i < 16; i++) begin
            feed(i % 4, 4);
            check_val("t4_hold", mean_s[i % 4], 16);
        end
        continuous = 1'b0;
        cycle();
        for (int k = 0; k < 4; k++) check_val("t4_second_mean", mean_s[k], 8);
        check_val("t4_second_pulse", pulse_s, 1);
        cycle();

        // 5: reset in the middle of a run
        start_small();
        feed(0, 6);
        feed(1, 6);
        rst = 1'b1;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        check_val("t5_busy_rst", busy_s, 0);
        check_val("t5_mean_rst", mean_s[3], 0);
        #2;
        rst = 1'b0;
        cycle();
        start_small();
        fill_small(6);
        cycle();
        for (int k = 0; k < 4; k++) check_val("t5_mean", mean_s[k], 12);

        // 6: start pulses during ACCUM and UPDATE are ignored
        start_small();
        for (int i = 0; i < 8; i++) feed(i % 4, 7);
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        for (int i = 8; i < 16; i++) feed(i % 4, 7);
        start_s = 1'b1;
        cycle();
        start_s = 1'b0;
        check_val("t6_mean", mean_s[2], 14);
        check_val("t6_busy_idle", busy_s, 0);
        cycle();
        check_val("t6_stays_idle", busy_s, 0);

        // 7: random sections, values and gaps against the model
        for (int run = 0; run < 6; run++) begin
            continuous = 1'($urandom);
            start_small();
            bound = 0;
            while (!m_upd[0] && bound < 400) begin
                sample_valid = ($urandom_range(0, 2) != 0);
                adc_section  = 2'($urandom);
                adc_sample   = 16'($urandom);
                cycle();
                bound++;
            end
            sample_valid = 1'b0;
            check_val("t7_run_done", m_upd[0], 1);
            continuous = 1'b0;
            cycle();
            if (m_run[0]) begin
                bound = 0;
                while (!m_upd[0] && bound < 400) begin
                    feed(bound % 4, int'($urandom_range(0, 65535)));
                    bound++;
                end
                check_val("t7_cont_done", m_upd[0], 1);
                cycle();
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/section_mean_estimator.md
Name: section_mean_estimator

Overview:
- Upstream producer of the four per-section ufix32 mean coefficients (mean_1..mean_4) consumed by the ADC-section mean selector.
- Accumulates 2^LOG2_N samples for each of the four ADC sections, tagged by adc_section.
- Converts each sum to a mean by right shift, keeping FRAC_W fractional bits.
- Publishes all four means together, and holds them stable while the next block is accumulated.

Parameters:
DATA_W, 16, unsigned ADC sample width.
LOG2_N, 10, log2 of the number of samples averaged per section (N = 2^LOG2_N).
FRAC_W, 4, fractional bits kept in each mean. Constraints: FRAC_W <= LOG2_N and DATA_W + FRAC_W <= 32.

Ports:
clk  in  1  system clock; everything is sampled on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin an estimation run; honoured only in IDLE.
continuous  in  1  when 1, a new run starts automatically after each update.
sample_valid  in  1  qualifies adc_sample and adc_section.
adc_section  in  2  section tag of the current sample (00 = section 1 … 11 = section 4).
adc_sample  in  DATA_W  unsigned ADC sample.
mean_1_o  out  32  section 1 mean, ufix32 with FRAC_W fractional bits.
mean_2_o  out  32  section 2 mean.
mean_3_o  out  32  section 3 mean.
mean_4_o  out  32  section 4 mean.
means_valid  out  1  sticky; set at the first update, cleared only by reset.
update_pulse  out  1  one-cycle strobe, coincident with new mean values appearing.
busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE;
  - the four accumulators and four counters are cleared;
  - mean_k_o = 0, means_valid = 0, update_pulse = 0, busy = 0.
- Storage:
  - Four accumulators, each DATA_W + LOG2_N bits wide; overflow is impossible.
  - Four sample counters, each LOG2_N + 1 bits wide.
- State machine: IDLE, ACCUM, UPDATE.
- IDLE:
  - start = 1 clears all accumulators and counters and moves to ACCUM on the next edge.
  - Samples presented in IDLE, including in the start cycle, are discarded.
- ACCUM:
  - On sample_valid = 1 with cnt[adc_section] < N: acc[adc_section] += adc_sample and cnt[adc_section] += 1.
  - A sample for a section whose count already equals N is discarded; no error is flagged.
  - When all four registered counts equal N, move to UPDATE.
  - start is ignored in ACCUM.
- UPDATE (exactly one cycle):
  - All incoming samples are discarded.
  - On the exiting edge: mean_k_o <= zero-extend(acc_k >> (LOG2_N - FRAC_W)) for k = 1..4, update_pulse <= 1, means_valid <= 1.
  - continuous is sampled in this cycle:
    - continuous = 1: clear accumulators and counters, return to ACCUM;
    - continuous = 0: go to IDLE.
  - start is ignored in UPDATE.
- Timing:
  - update_pulse is high for exactly the single cycle after UPDATE.
  - The edge that accepts the last required sample puts the FSM in UPDATE; the next edge presents the new means.
  - Latency from the last accepted sample to new outputs: 2 clock edges.
- Output stability:
  - mean_k_o change only on the UPDATE-exit edge or on reset.
  - The downstream selector never sees a partial or mixed update.
- busy: combinational decode of state != IDLE, or an equivalent register.
- Reset mid-run: the partial run is discarded. Previously published means are also lost (reset value 0).

Test Plan:
1. Bench override LOG2_N=2, FRAC_W=1. After start, feed four samples per section:
   - section 0: 10, 11, 12, 13;
   - section 1: 100 ×4;
   - section 2: 0 ×4;
   - section 3: 65535 ×4.
   -> mean_1 = 23, mean_2 = 200, mean_3 = 0, mean_4 = 131070; a single update_pulse; means_valid = 1; busy falls the following cycle.
2. Same config, section 0 given 10..15 (six samples) before the other sections fill -> the last two are discarded, mean_1 = 23; a sample presented during UPDATE is also discarded.
3. Round-robin sections with random sample_valid gaps (defaults, N = 1024, constant sample 1000 per section) -> every mean = 16000 (1000 << 4), with update exactly 2 edges after the 4096th accepted sample.
4. continuous = 1:
   - first run with all 8 -> means 16;
   - second run with all 4 -> outputs hold 16 throughout the second accumulation, then switch to 8 on the second update_pulse.
5. Assert rst mid-ACCUM -> immediately all outputs 0, busy = 0, means_valid = 0; then start and a full run with all 6 -> means 12 (LOG2_N=2, FRAC_W=1).
6. Pulse start during ACCUM and during UPDATE -> no restart, counts unaffected; with continuous = 0, FSM returns to IDLE after one update.
